axil_arb_rr: RTL and testbench
==============================

AXIL_ARB_RR -- requirements
Module: axil_arb_rr

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: address bus width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: wstrb width.
REQ-004 Parameter S_COUNT, default 2, legal 2..4: number of upstream AXI-lite requesters.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Ports s_axil_aw{addr,prot,valid,ready}, in/in/in/out, S_COUNT x {ADDR_WIDTH,3,1,1}, concatenated: requester AW channels.
REQ-008 Ports s_axil_w{data,strb,valid,ready}, in/in/in/out, S_COUNT x {DATA_WIDTH,STRB_WIDTH,1,1}: requester W channels.
REQ-009 Ports s_axil_b{resp,valid,ready}, out/out/in, S_COUNT x {2,1,1}: requester B channels.
REQ-010 Ports s_axil_ar{addr,prot,valid,ready}, in/in/in/out, S_COUNT x {ADDR_WIDTH,3,1,1}: requester AR channels.
REQ-011 Ports s_axil_r{data,resp,valid,ready}, out/out/out/in, S_COUNT x {DATA_WIDTH,2,1,1}: requester R channels.
REQ-012 Ports m_axil_* (aw,w,b,ar,r), mirror directions, single-width: shared downstream AXI-lite slave port.

Function
REQ-013 Write and read paths SHALL be arbitrated by independent FSMs; one write and one read may be in flight simultaneously.
REQ-014 Each FSM SHALL have states IDLE, ADDR, RESP; at most one transaction outstanding per direction.
REQ-015 In IDLE, write arbiter SHALL grant among ports with awvalid=1 (wvalid alone never requests); read arbiter among arvalid=1.
REQ-016 Grant SHALL be round-robin: search starts at last-granted index+1 modulo S_COUNT; after reset, index 0 has highest priority.
REQ-017 Grant registers on the IDLE cycle a request is seen (cycle N) and FSM enters ADDR; m_axil_awvalid/arvalid first asserts at N+1.
REQ-018 In write ADDR, AW and W of the granted port SHALL pass through combinationally (valid, ready, payload muxed) and complete independently; FSM enters RESP on the cycle both handshakes are done (same-cycle or either order).
REQ-019 In read ADDR, AR passes through; FSM enters RESP on AR handshake.
REQ-020 In RESP, m_axil_b*/r* SHALL be routed to the granted port only; m_axil_bready/rready = granted port's bready/rready; FSM returns to IDLE on the B/R handshake and last-granted index updates to grant.
REQ-021 Non-granted ports SHALL see all ready and valid outputs 0; their payload outputs are don't-care (driven 0).
REQ-022 New grant SHALL NOT occur on the cycle of the response handshake; earliest next grant is the following IDLE cycle (two-cycle minimum gap).
REQ-023 A requester that drops awvalid/arvalid before handshake violates AXI; behaviour unspecified but FSM SHALL not deadlock the other direction.
REQ-024 Responses SHALL be forwarded unmodified (bresp/rresp/rdata).

Reset
REQ-025 While rst=1: both FSMs IDLE, last-granted index = S_COUNT-1, all m_axil_*valid, m_axil_bready/rready, all s_axil_*ready and s_axil_bvalid/rvalid SHALL be 0 on the following cycle.
REQ-026 Reset mid-transaction SHALL abandon it; no response is delivered to any requester afterward.

Structure
REQ-027 Package axil_arb_pkg SHALL hold the FSM state enum (IDLE/ADDR/RESP) and AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR).
REQ-028 One sub-module axil_rr_arb (request vector, last index -> one-hot grant + index) SHALL be instantiated twice, write and read.

Verification
REQ-029 Port0 and port1 assert awvalid together at cycle 1 after reset -> port0 granted, m_awaddr=port0 addr at cycle 2; next simultaneous request grants port1.
REQ-030 Port1 issues wvalid 3 cycles before awvalid -> no m_wvalid until AW grant; AW/W complete, bresp=OKAY returned only to port1.
REQ-031 Port0 write and port1 read concurrently, downstream returns rresp=SLVERR, rdata=0xDEADBEEF -> port1 receives exactly that; port0 receives its B independently.
REQ-032 Downstream holds bvalid with port0 bready=0 for 5 cycles -> FSM stays RESP, no new write grant, port1 awready=0 throughout.
REQ-033 rst=1 asserted in write ADDR after AW handshake but before W -> next cycle all valids/readies 0; subsequent port1 request granted normally with index0 priority restored.
REQ-034 Formal bench: bind AXI-lite slave-side properties on every port; cover back-to-back grants to all S_COUNT ports.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the round-robin AXI-lite arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_rr_arb.sv
// Combinational round-robin picker: search starts one past the last-granted index.
module axil_rr_arb #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    // Both loops unroll; the inner one keeps every request bit select constant.
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!o_valid && i_req[j] && (j == ((int'(i_last) + k) % N))) begin
          o_valid    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axil_arb_rr.sv
// N:1 AXI-lite arbiter with independent round-robin write and read FSMs
// (IDLE -> ADDR -> RESP), one outstanding transaction per direction.
module axil_arb_rr
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int S_COUNT    = 2
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]             s_axil_awprot,
  input  logic [S_COUNT-1:0]               s_axil_awvalid,
  output logic [S_COUNT-1:0]               s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0]    s_axil_wstrb,
  input  logic [S_COUNT-1:0]               s_axil_wvalid,
  output logic [S_COUNT-1:0]               s_axil_wready,
  output logic [S_COUNT*2-1:0]             s_axil_bresp,
  output logic [S_COUNT-1:0]               s_axil_bvalid,
  input  logic [S_COUNT-1:0]               s_axil_bready,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [S_COUNT*3-1:0]             s_axil_arprot,
  input  logic [S_COUNT-1:0]               s_axil_arvalid,
  output logic [S_COUNT-1:0]               s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [S_COUNT*2-1:0]             s_axil_rresp,
  output logic [S_COUNT-1:0]               s_axil_rvalid,
  input  logic [S_COUNT-1:0]               s_axil_rready,

  output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
  output logic [2:0]                       m_axil_awprot,
  output logic                             m_axil_awvalid,
  input  logic                             m_axil_awready,
  output logic [DATA_WIDTH-1:0]            m_axil_wdata,
  output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
  output logic                             m_axil_wvalid,
  input  logic                             m_axil_wready,
  input  logic [1:0]                       m_axil_bresp,
  input  logic                             m_axil_bvalid,
  output logic                             m_axil_bready,
  output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
  output logic [2:0]                       m_axil_arprot,
  output logic                             m_axil_arvalid,
  input  logic                             m_axil_arready,
  input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  input  logic                             m_axil_rvalid,
  output logic                             m_axil_rready
);

  localparam int IW = $clog2(S_COUNT);

  arb_state_t         r_wr_state, r_rd_state;
  logic [IW-1:0]      r_wr_idx, r_wr_last, r_rd_idx, r_rd_last;
  logic [S_COUNT-1:0] r_wr_oh, r_rd_oh;
  logic               r_aw_done, r_w_done;

  logic               w_wr_req_valid, w_rd_req_valid;
  logic [S_COUNT-1:0] w_wr_req_oh, w_rd_req_oh;
  logic [IW-1:0]      w_wr_req_idx, w_rd_req_idx;
  logic               w_sel_awvalid, w_sel_wvalid, w_sel_bready;
  logic               w_sel_arvalid, w_sel_rready;
  logic               w_wr_addr, w_wr_resp, w_rd_addr, w_rd_resp;
  logic               w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic               w_aw_open, w_w_open;

  axil_rr_arb #(.N(S_COUNT), .IW(IW)) u_wr_arb (
    .i_req   (s_axil_awvalid),
    .i_last  (r_wr_last),
    .o_valid (w_wr_req_valid),
    .o_grant (w_wr_req_oh),
    .o_idx   (w_wr_req_idx)
  );

  axil_rr_arb #(.N(S_COUNT), .IW(IW)) u_rd_arb (
    .i_req   (s_axil_arvalid),
    .i_last  (r_rd_last),
    .o_valid (w_rd_req_valid),
    .o_grant (w_rd_req_oh),
    .o_idx   (w_rd_req_idx)
  );

  always_comb begin
    m_axil_awaddr = '0;
    m_axil_awprot = '0;
    m_axil_wdata  = '0;
    m_axil_wstrb  = '0;
    m_axil_araddr = '0;
    m_axil_arprot = '0;
    w_sel_awvalid = 1'b0;
    w_sel_wvalid  = 1'b0;
    w_sel_bready  = 1'b0;
    w_sel_arvalid = 1'b0;
    w_sel_rready  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (r_wr_idx == IW'(i)) begin
        m_axil_awaddr = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_awprot = s_axil_awprot[i*3 +: 3];
        m_axil_wdata  = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axil_wstrb  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        w_sel_awvalid = s_axil_awvalid[i];
        w_sel_wvalid  = s_axil_wvalid[i];
        w_sel_bready  = s_axil_bready[i];
      end
      if (r_rd_idx == IW'(i)) begin
        m_axil_araddr = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_arprot = s_axil_arprot[i*3 +: 3];
        w_sel_arvalid = s_axil_arvalid[i];
        w_sel_rready  = s_axil_rready[i];
      end
    end
  end

  assign w_wr_addr = (r_wr_state == ST_ADDR);
  assign w_wr_resp = (r_wr_state == ST_RESP);
  assign w_rd_addr = (r_rd_state == ST_ADDR);
  assign w_rd_resp = (r_rd_state == ST_RESP);

  // AW and W close independently; each channel is shut once its handshake is done.
  assign w_aw_open = w_wr_addr && !r_aw_done;
  assign w_w_open  = w_wr_addr && !r_w_done;

  assign m_axil_awvalid = w_aw_open && w_sel_awvalid;
  assign m_axil_wvalid  = w_w_open && w_sel_wvalid;
  assign m_axil_bready  = w_wr_resp && w_sel_bready;
  assign m_axil_arvalid = w_rd_addr && w_sel_arvalid;
  assign m_axil_rready  = w_rd_resp && w_sel_rready;

  assign w_aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_w_hs  = m_axil_wvalid && m_axil_wready;
  assign w_b_hs  = m_axil_bvalid && m_axil_bready;
  assign w_ar_hs = m_axil_arvalid && m_axil_arready;
  assign w_r_hs  = m_axil_rvalid && m_axil_rready;

  assign s_axil_awready = {S_COUNT{w_aw_open && m_axil_awready}} & r_wr_oh;
  assign s_axil_wready  = {S_COUNT{w_w_open && m_axil_wready}} & r_wr_oh;
  assign s_axil_bvalid  = {S_COUNT{w_wr_resp && m_axil_bvalid}} & r_wr_oh;
  assign s_axil_arready = {S_COUNT{w_rd_addr && m_axil_arready}} & r_rd_oh;
  assign s_axil_rvalid  = {S_COUNT{w_rd_resp && m_axil_rvalid}} & r_rd_oh;

  always_comb begin
    s_axil_bresp = '0;
    s_axil_rresp = '0;
    s_axil_rdata = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (w_wr_resp && r_wr_oh[i]) begin
        s_axil_bresp[i*2 +: 2] = m_axil_bresp;
      end
      if (w_rd_resp && r_rd_oh[i]) begin
        s_axil_rresp[i*2 +: 2]                 = m_axil_rresp;
        s_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= ST_IDLE;
      r_wr_last  <= IW'(S_COUNT - 1);
      r_wr_idx   <= '0;
      r_wr_oh    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        ST_IDLE: begin
          if (w_wr_req_valid) begin
            r_wr_idx   <= w_wr_req_idx;
            r_wr_oh    <= w_wr_req_oh;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          r_aw_done <= r_aw_done || w_aw_hs;
          r_w_done  <= r_w_done || w_w_hs;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_wr_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_wr_last  <= r_wr_idx;
            r_wr_state <= ST_IDLE;
          end
        end
        default: r_wr_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= ST_IDLE;
      r_rd_last  <= IW'(S_COUNT - 1);
      r_rd_idx   <= '0;
      r_rd_oh    <= '0;
    end else begin
      case (r_rd_state)
        ST_IDLE: begin
          if (w_rd_req_valid) begin
            r_rd_idx   <= w_rd_req_idx;
            r_rd_oh    <= w_rd_req_oh;
            r_rd_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_rd_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_r_hs) begin
            r_rd_last  <= r_rd_idx;
            r_rd_state <= ST_IDLE;
          end
        end
        default: r_rd_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arb_rr.sv
// Directed bench for axil_arb_rr: a cycle table for the write path plus
// hand-written multi-cycle sequences for the corner cases.
module tb_axil_arb_rr;
  import axil_arb_pkg::*;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;
  localparam logic [31:0] D0 = 32'h3333_4444;
  localparam logic [31:0] D1 = 32'h1111_2222;
  localparam logic [31:0] R0 = 32'h0000_0100;
  localparam logic [31:0] R1 = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axil_awaddr;
  logic [5:0]  s_axil_awprot;
  logic [1:0]  s_axil_awvalid, s_axil_awready;
  logic [63:0] s_axil_wdata;
  logic [7:0]  s_axil_wstrb;
  logic [1:0]  s_axil_wvalid, s_axil_wready;
  logic [3:0]  s_axil_bresp;
  logic [1:0]  s_axil_bvalid, s_axil_bready;
  logic [63:0] s_axil_araddr;
  logic [5:0]  s_axil_arprot;
  logic [1:0]  s_axil_arvalid, s_axil_arready;
  logic [63:0] s_axil_rdata;
  logic [3:0]  s_axil_rresp;
  logic [1:0]  s_axil_rvalid, s_axil_rready;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axil_arb_rr #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .S_COUNT(2)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  typedef struct packed {
    logic [1:0]  awv, wv;
    logic        awr, wr, bv;
    logic [1:0]  br, bresp;
    logic        e_awv, e_wv;
    logic [1:0]  e_awr, e_wr, e_bv;
    logic        e_br;
    logic [31:0] e_addr;
    logic [3:0]  e_bresp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    // awv wv awr wr bv br bresp | e_awv e_wv e_awr e_wr e_bv e_br e_addr e_bresp
    tbl[0]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 4'h0};
    tbl[1]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, A0,    4'h0};
    tbl[2]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 32'h0, 4'h1};
    tbl[3]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 4'h0};
    tbl[4]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0, A1,    4'h0};
    tbl[5]  = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 32'h0, 4'h8};
    tbl[6]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 4'h0};
    tbl[7]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0, A0,    4'h0};
    tbl[8]  = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, A0,    4'h0};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 32'h0, 4'h3};
    tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 32'h0, 4'h3};
    tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 4'h0};

    rst = 1'b1;
    s_axil_awaddr = {A1, A0};  s_axil_awprot = 6'b010_001;
    s_axil_wdata  = {D1, D0};  s_axil_wstrb  = 8'hFF;
    s_axil_araddr = {R1, R0};  s_axil_arprot = 6'b000_000;
    s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11; s_axil_bready = 2'b11;
    s_axil_arvalid = 2'b11; s_axil_rready = 2'b11;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bresp = 2'b00; m_axil_bvalid = 1'b1;
    m_axil_arready = 1'b1; m_axil_rdata = '0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b1;

    // Requests and responses held high during reset must not leak through.
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst m_awvalid", m_axil_awvalid, 0);
    chk("rst m_arvalid", m_axil_arvalid, 0);
    chk("rst m_bready",  m_axil_bready, 0);
    chk("rst m_rready",  m_axil_rready, 0);
    chk("rst s_ready",   {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    chk("rst s_valid",   {s_axil_bvalid, s_axil_rvalid}, 0);
    s_axil_arvalid = 2'b00; s_axil_rready = 2'b00; m_axil_rvalid = 1'b0;
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      s_axil_awvalid = tbl[i].awv;  s_axil_wvalid = tbl[i].wv;
      m_axil_awready = tbl[i].awr;  m_axil_wready = tbl[i].wr;
      m_axil_bvalid  = tbl[i].bv;   s_axil_bready = tbl[i].br;
      m_axil_bresp   = tbl[i].bresp;
      @(negedge clk);
      chk($sformatf("row%0d m_awvalid", i), m_axil_awvalid, tbl[i].e_awv);
      chk($sformatf("row%0d m_wvalid", i),  m_axil_wvalid,  tbl[i].e_wv);
      chk($sformatf("row%0d s_awready", i), s_axil_awready, tbl[i].e_awr);
      chk($sformatf("row%0d s_wready", i),  s_axil_wready,  tbl[i].e_wr);
      chk($sformatf("row%0d s_bvalid", i),  s_axil_bvalid,  tbl[i].e_bv);
      chk($sformatf("row%0d m_bready", i),  m_axil_bready,  tbl[i].e_br);
      chk($sformatf("row%0d s_bresp", i),   s_axil_bresp,   tbl[i].e_bresp);
      if (tbl[i].e_awv) chk($sformatf("row%0d m_awaddr", i), m_axil_awaddr, tbl[i].e_addr);
      next_cycle();
    end
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00; m_axil_bresp = 2'b00;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1;

    // W presented well ahead of AW must wait for the AW grant.
    s_axil_wvalid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("early_w m_wvalid", m_axil_wvalid, 0);
      chk("early_w s_wready", s_axil_wready, 0);
      next_cycle();
    end
    s_axil_awvalid = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (m_axil_awvalid) found = 1'b1;
      else next_cycle();
    end
    chk("early_w aw_grant_wait", found, 1);
    chk("early_w m_awaddr", m_axil_awaddr, A1);
    chk("early_w m_wvalid_on", m_axil_wvalid, 1);
    chk("early_w m_wdata", m_axil_wdata, D1);
    chk("early_w s_awready", s_axil_awready, 2'b10);
    next_cycle();
    s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00;
    m_axil_bvalid = 1'b1; m_axil_bresp = RESP_OKAY; s_axil_bready = 2'b11;
    @(negedge clk);
    chk("early_w s_bvalid", s_axil_bvalid, 2'b10);
    chk("early_w s_bresp", s_axil_bresp, 4'h0);
    next_cycle();
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;

    // Concurrent port0 write and port1 read.
    s_axil_awvalid = 2'b01; s_axil_wvalid = 2'b01; s_axil_arvalid = 2'b10;
    @(negedge clk);
    chk("conc idle m_arvalid", m_axil_arvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("conc m_awvalid", m_axil_awvalid, 1);
    chk("conc m_awaddr", m_axil_awaddr, A0);
    chk("conc m_arvalid", m_axil_arvalid, 1);
    chk("conc m_araddr", m_axil_araddr, R1);
    chk("conc s_arready", s_axil_arready, 2'b10);
    chk("conc s_awready", s_axil_awready, 2'b01);
    next_cycle();
    s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; s_axil_arvalid = 2'b00;
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'hDEAD_BEEF; m_axil_rresp = RESP_SLVERR; s_axil_rready = 2'b10;
    @(negedge clk);
    chk("conc s_rvalid", s_axil_rvalid, 2'b10);
    chk("conc s_rdata", s_axil_rdata, {32'hDEAD_BEEF, 32'h0});
    chk("conc s_rresp", s_axil_rresp, 4'b1000);
    chk("conc m_rready", m_axil_rready, 1);
    chk("conc s_bvalid_early", s_axil_bvalid, 2'b00);
    next_cycle();
    m_axil_rvalid = 1'b0; s_axil_rready = 2'b00;
    m_axil_bvalid = 1'b1; m_axil_bresp = RESP_OKAY; s_axil_bready = 2'b01;
    @(negedge clk);
    chk("conc s_bvalid", s_axil_bvalid, 2'b01);
    chk("conc s_rvalid_done", s_axil_rvalid, 2'b00);
    next_cycle();
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;

    // Reset after AW handshake, before W; last grant was port0.
    s_axil_awvalid = 2'b01; s_axil_wvalid = 2'b00;
    next_cycle();
    @(negedge clk);
    chk("rstmid s_awready", s_axil_awready, 2'b01);
    next_cycle();
    s_axil_awvalid = 2'b00;
    @(negedge clk);
    chk("rstmid m_awvalid_done", m_axil_awvalid, 0);
    chk("rstmid s_wready_open", s_axil_wready, 2'b01);
    next_cycle();
    rst = 1'b1; m_axil_bvalid = 1'b1; s_axil_bready = 2'b11;
    next_cycle();
    @(negedge clk);
    chk("rstmid outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_axil_awready, s_axil_wready, s_axil_bvalid}, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid no_b_after", s_axil_bvalid, 2'b00);
    chk("rstmid no_bready_after", m_axil_bready, 0);
    m_axil_bvalid = 1'b0;
    s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11;
    next_cycle();
    @(negedge clk);
    chk("rstmid prio s_awready", s_axil_awready, 2'b01);
    chk("rstmid prio m_awaddr", m_axil_awaddr, A0);
    next_cycle();
    s_axil_awvalid = 2'b10; s_axil_wvalid = 2'b10; m_axil_bvalid = 1'b1;
    @(negedge clk);
    chk("rstmid b0", s_axil_bvalid, 2'b01);
    next_cycle();
    m_axil_bvalid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rstmid p1 s_awready", s_axil_awready, 2'b10);
    chk("rstmid p1 m_awaddr", m_axil_awaddr, A1);
    next_cycle();
    s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; m_axil_bvalid = 1'b1;
    @(negedge clk);
    chk("rstmid b1", s_axil_bvalid, 2'b10);
    next_cycle();
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;

    // Stalled B response blocks further write grants.
    s_axil_awvalid = 2'b01; s_axil_wvalid = 2'b01;
    next_cycle();
    @(negedge clk);
    chk("bstall m_awaddr", m_axil_awaddr, A0);
    next_cycle();
    s_axil_awvalid = 2'b10; s_axil_wvalid = 2'b10;
    m_axil_bvalid = 1'b1; m_axil_bresp = RESP_EXOKAY; s_axil_bready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bstall s_awready", s_axil_awready, 2'b00);
      chk("bstall m_awvalid", m_axil_awvalid, 0);
      chk("bstall s_bvalid", s_axil_bvalid, 2'b01);
      chk("bstall m_bready", m_axil_bready, 0);
      next_cycle();
    end
    s_axil_bready = 2'b01;
    @(negedge clk);
    chk("bstall release m_bready", m_axil_bready, 1);
    chk("bstall s_bresp", s_axil_bresp, 4'b0001);
    next_cycle();
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;
    @(negedge clk);
    chk("bstall gap m_awvalid", m_axil_awvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("bstall p1 m_awaddr", m_axil_awaddr, A1);
    chk("bstall p1 s_awready", s_axil_awready, 2'b10);
    next_cycle();
    s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00;
    m_axil_bvalid = 1'b1; s_axil_bready = 2'b10;
    @(negedge clk);
    chk("bstall p1 s_bvalid", s_axil_bvalid, 2'b10);
    next_cycle();
    m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
